rtp_result_collector: RTL and testbench

Result-side counterpart of the ray loader in the RTP pipeline. The loader fills ray-origin, direction, inverse-direction and hitT buffers before traversal. This block accepts per-ray hit results (ray id, hitT, hitIndex) that the traversal core retires out of order, and buffers them. It drains them in ascending ray-id order on a valid/ready stream toward the host/dump path. It also reports frame completion and protocol errors.

---
 rtl/rtp_pkg.sv | 21 ++
 rtl/rtp_result_ram.sv | 36 +++
 rtl/rtp_result_collector.sv | 178 +++++++++++++++++
 tb/tb_rtp_result_collector.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtp_pkg.sv
// rtp_pkg: types and constants shared by the RTP result-side blocks.
//   rtp_result_t       - one stored hit result {hitT, hitIndex}
//   RTP_MISS_INDEX     - hitIndex value that marks a miss
//   collector_state_t  - state encoding of rtp_result_collector
package rtp_pkg;

  localparam int RTP_DATA_W = 32;
  localparam logic [RTP_DATA_W-1:0] RTP_MISS_INDEX = 32'hFFFFFFFF;

  typedef struct packed {
    logic [RTP_DATA_W-1:0] hitT;
    logic [RTP_DATA_W-1:0] hitIndex;
  } rtp_result_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collector_state_t;

endpackage

// File: rtl/rtp_result_ram.sv
// rtp_result_ram: simple dual-port result store, one write port and one
// synchronous read port with 1-cycle latency.
// Ports:
//   clock, reset        - clock; async active-high reset (read register only)
//   wr_en/wr_addr/wr_data - write port
//   rd_en/rd_addr       - read request; rd_data updates on the next edge
//   rd_data             - read register; holds its value while rd_en is low,
//                         which is what lets the collector use it directly as
//                         the data half of its output register.
module rtp_result_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rtp_result_collector.sv
// rtp_result_collector: accepts out-of-order per-ray hit results from the
// traversal core, buffers them, and drains them in ascending ray-id order.
//
// Optional feature macro: RTP_RESULT_STATS_EN adds io_hit_count/io_miss_count.
//
// Ports:
//   clock, reset                 - clock; async active-high reset
//   io_start, io_num_rays        - begin a frame (honoured only in IDLE)
//   io_res_*                     - result input stream (ready only in COLLECT)
//   io_out_*                     - ordered output stream
//   io_busy, io_done             - not-IDLE status; one-cycle frame-done pulse
//   io_dup_err, io_range_err     - sticky protocol errors, cleared on start
//   io_hit_count, io_miss_count  - (RTP_RESULT_STATS_EN only) per-frame counts
//
// Stream handshakes: a transfer happens on a rising edge where valid and
// ready are both high; valid never waits on ready, and the output payload
// stays stable while io_out_valid is high and io_out_ready is low.
module rtp_result_collector
  import rtp_pkg::*;
#(
  parameter int NUM_RAYS = 1024,
  parameter int ID_W     = 10,
  parameter int DATA_W   = RTP_DATA_W   // must match the package result width
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ID_W:0]     io_num_rays,
  input  logic              io_res_valid,
  output logic              io_res_ready,
  input  logic [ID_W-1:0]   io_res_rayId,
  input  logic [DATA_W-1:0] io_res_hitT,
  input  logic [DATA_W-1:0] io_res_hitIndex,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [ID_W-1:0]   io_out_rayId,
  output logic [DATA_W-1:0] io_out_hitT,
  output logic [DATA_W-1:0] io_out_hitIndex,
`ifdef RTP_RESULT_STATS_EN
  output logic [ID_W:0]     io_hit_count,
  output logic [ID_W:0]     io_miss_count,
`endif
  output logic              io_busy,
  output logic              io_done,
  output logic              io_dup_err,
  output logic              io_range_err
);

  collector_state_t  state;
  logic [ID_W:0]     num_rays;
  logic [ID_W:0]     rd_ptr;
  logic [NUM_RAYS-1:0] valid_map;
  logic              out_valid;
  logic [ID_W-1:0]   out_ray_id;
  logic              dup_err;
  logic              range_err;

  logic              start_acc;
  logic              res_fire;
  logic              range_bad;
  logic              dup_bad;
  logic              acc_ok;
  logic [ID_W-1:0]   rd_idx;
  logic              drain;
  rtp_result_t       wr_res;
  rtp_result_t       rd_res;

  assign start_acc = io_start && (state == ST_IDLE);
  assign res_fire  = io_res_valid && io_res_ready;

  // Range is checked before duplication, so an out-of-range id never reaches
  // the bitmap lookup (its low bits could alias a legal entry).
  assign range_bad = ({1'b0, io_res_rayId} >= num_rays);
  assign dup_bad   = !range_bad &&
                     (({1'b0, io_res_rayId} < rd_ptr) || valid_map[io_res_rayId]);
  assign acc_ok    = res_fire && !range_bad && !dup_bad;

  // Head-of-line entry moves into the output register when that register is
  // free now or is being emptied on this same edge.
  assign rd_idx = rd_ptr[ID_W-1:0];
  assign drain  = (state == ST_COLLECT) && (rd_ptr < num_rays) &&
                  valid_map[rd_idx] && (!out_valid || io_out_ready);

  assign wr_res.hitT     = io_res_hitT;
  assign wr_res.hitIndex = io_res_hitIndex;

  rtp_result_ram #(
    .DEPTH (NUM_RAYS),
    .AW    (ID_W),
    .W     ($bits(rtp_result_t))
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (acc_ok),
    .wr_addr (io_res_rayId),
    .wr_data (wr_res),
    .rd_en   (drain),
    .rd_addr (rd_idx),
    .rd_data (rd_res)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      num_rays   <= '0;
      rd_ptr     <= '0;
      valid_map  <= '0;
      out_valid  <= 1'b0;
      out_ray_id <= '0;
      dup_err    <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_start) begin
            state     <= ST_COLLECT;
            num_rays  <= io_num_rays;
            rd_ptr    <= '0;
            valid_map <= '0;
            dup_err   <= 1'b0;
            range_err <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if ((rd_ptr == num_rays) && !out_valid) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Accepts only happen in COLLECT, so they never collide with the
      // bitmap clear done by an accepted start in IDLE.
      if (res_fire) begin
        if (range_bad)    range_err <= 1'b1;
        else if (dup_bad) dup_err   <= 1'b1;
        else              valid_map[io_res_rayId] <= 1'b1;
      end

      if (drain) begin
        valid_map[rd_idx] <= 1'b0;
        rd_ptr            <= rd_ptr + (ID_W+1)'(1);
        out_valid         <= 1'b1;
        out_ray_id        <= rd_idx;
      end else if (out_valid && io_out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RTP_RESULT_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_hit_count  <= '0;
      io_miss_count <= '0;
    end else if (start_acc) begin
      io_hit_count  <= '0;
      io_miss_count <= '0;
    end else if (acc_ok) begin
      if (io_res_hitIndex == RTP_MISS_INDEX) io_miss_count <= io_miss_count + (ID_W+1)'(1);
      else                                   io_hit_count  <= io_hit_count + (ID_W+1)'(1);
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

  assign io_res_ready    = (state == ST_COLLECT);
  assign io_busy         = (state != ST_IDLE);
  assign io_done         = (state == ST_DONE);
  assign io_out_valid    = out_valid;
  assign io_out_rayId    = out_ray_id;
  assign io_out_hitT     = rd_res.hitT;
  assign io_out_hitIndex = rd_res.hitIndex;
  assign io_dup_err      = dup_err;
  assign io_range_err    = range_err;

endmodule

// File: tb/tb_rtp_result_collector.sv
// Directed bench for rtp_result_collector: ordered-drain scoreboard, latency,
// backpressure, error flags, zero-ray frame and mid-frame reset.
module tb_rtp_result_collector;
  import rtp_pkg::*;

  localparam int ID_W   = 10;
  localparam int DATA_W = 32;
  localparam int EW     = ID_W + 2*DATA_W;

  logic              clock;
  logic              reset;
  logic              io_start;
  logic [ID_W:0]     io_num_rays;
  logic              io_res_valid;
  logic              io_res_ready;
  logic [ID_W-1:0]   io_res_rayId;
  logic [DATA_W-1:0] io_res_hitT;
  logic [DATA_W-1:0] io_res_hitIndex;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [ID_W-1:0]   io_out_rayId;
  logic [DATA_W-1:0] io_out_hitT;
  logic [DATA_W-1:0] io_out_hitIndex;
  logic              io_busy;
  logic              io_done;
  logic              io_dup_err;
  logic              io_range_err;
`ifdef RTP_RESULT_STATS_EN
  logic [ID_W:0]     io_hit_count;
  logic [ID_W:0]     io_miss_count;
`endif

  rtp_result_collector dut (
    .clock           (clock),
    .reset           (reset),
    .io_start        (io_start),
    .io_num_rays     (io_num_rays),
    .io_res_valid    (io_res_valid),
    .io_res_ready    (io_res_ready),
    .io_res_rayId    (io_res_rayId),
    .io_res_hitT     (io_res_hitT),
    .io_res_hitIndex (io_res_hitIndex),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_rayId    (io_out_rayId),
    .io_out_hitT     (io_out_hitT),
    .io_out_hitIndex (io_out_hitIndex),
`ifdef RTP_RESULT_STATS_EN
    .io_hit_count    (io_hit_count),
    .io_miss_count   (io_miss_count),
`endif
    .io_busy         (io_busy),
    .io_done         (io_done),
    .io_dup_err      (io_dup_err),
    .io_range_err    (io_range_err)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters / scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int ovalid_cnt = 0;

  logic [EW-1:0] exp_q[$];

  // model of the frame: which ids are buffered and the next id to emit
  int            m_n;
  int            m_ptr;
  bit            m_valid [1024];
  logic [EW-1:0] m_data  [1024];
  bit            m_dup;
  bit            m_range;
  int            m_hits;
  int            m_miss;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr   = 0;
    m_dup   = 0;
    m_range = 0;
    m_hits  = 0;
    m_miss  = 0;
    for (int i = 0; i < 1024; i++) m_valid[i] = 0;
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  logic          hold_pend = 1'b0;
  logic [EW:0]   hold_val;

  always @(negedge clock) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (io_done) done_cnt++;
      if (io_out_valid) ovalid_cnt++;
      if (hold_pend)
        chk("hold_stable", {io_out_valid, io_out_rayId, io_out_hitT, io_out_hitIndex}, hold_val);
      hold_pend = io_out_valid && !io_out_ready;
      hold_val  = {io_out_valid, io_out_rayId, io_out_hitT, io_out_hitIndex};
      if (io_out_valid && io_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {io_out_rayId, io_out_hitT, io_out_hitIndex}, '1);
        end else begin
          chk("out_payload", {io_out_rayId, io_out_hitT, io_out_hitIndex}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input int n);
    io_start    = 1'b1;
    io_num_rays = n[ID_W:0];
    tick();
    io_start    = 1'b0;
    m_n = n;
    model_clear();
  endtask

  // drive one result for one cycle (DUT is in COLLECT, so ready is high)
  task automatic send(input int id, input logic [31:0] t, input logic [31:0] hi);
    io_res_valid    = 1'b1;
    io_res_rayId    = id[ID_W-1:0];
    io_res_hitT     = t;
    io_res_hitIndex = hi;
    if (id >= m_n) m_range = 1;
    else if (id < m_ptr || m_valid[id]) m_dup = 1;
    else begin
      m_valid[id] = 1;
      m_data[id]  = {id[ID_W-1:0], t, hi};
      if (hi == RTP_MISS_INDEX) m_miss++; else m_hits++;
      while (m_ptr < m_n && m_valid[m_ptr]) begin
        exp_q.push_back(m_data[m_ptr]);
        m_valid[m_ptr] = 0;
        m_ptr++;
      end
    end
    tick();
    io_res_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (io_done) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    tick();
    chk({tag, "_done_one_cycle"}, io_done, 1'b0);
    chk({tag, "_busy_after"}, io_busy, 1'b0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int d0;
  int v0;

  initial begin
    reset = 1'b1;
    io_start = 0; io_num_rays = '0; io_res_valid = 0; io_res_rayId = '0;
    io_res_hitT = '0; io_res_hitIndex = '0; io_out_ready = 1'b1;
    m_n = 0;
    model_clear();
    #2;
    chk("rst_res_ready", io_res_ready, 1'b0);
    chk("rst_outputs", {io_out_valid, io_out_rayId, io_out_hitT, io_out_hitIndex,
                        io_busy, io_done, io_dup_err, io_range_err}, '0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // In-order frame with latency check
    d0 = done_cnt;
    start_frame(4);
    chk("inord_busy", {io_busy, io_res_ready}, 2'b11);
    send(0, 32'h3f800000, 32'd10);
    chk("inord_lat_n1", io_out_valid, 1'b0);
    send(1, 32'h40000000, 32'd11);
    chk("inord_lat_n2", {io_out_valid, io_out_rayId}, {1'b1, 10'd0});
    send(2, 32'h40400000, 32'd12);
    send(3, 32'h40800000, RTP_MISS_INDEX);
    wait_done("inord", 20);
    chk("inord_done_pulses", done_cnt - d0, 1);

    // Reverse order: nothing until id 0, then back-to-back 0..3
    start_frame(4);
    send(3, 32'h00000033, 32'd33);
    send(2, 32'h00000022, 32'd22);
    send(1, 32'h00000011, 32'd11);
    tick(); tick();
    chk("rev_no_early_out", io_out_valid, 1'b0);
    send(0, 32'h00000000, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rev_consecutive", {io_out_valid, io_out_rayId}, {1'b1, i[ID_W-1:0]});
      tick();
    end
    wait_done("rev", 20);

    // Backpressure: two results pending while output is stalled
    start_frame(4);
    io_out_ready = 1'b0;
    send(0, 32'haaaa0000, 32'd100);
    send(1, 32'hbbbb0000, 32'd101);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_held", {io_out_valid, io_out_rayId, io_out_hitIndex}, {1'b1, 10'd0, 32'd100});
    io_out_ready = 1'b1;
    send(2, 32'hcccc0000, 32'd102);
    send(3, 32'hdddd0000, 32'd103);
    wait_done("bp", 20);

    // Errors: duplicate id 1 and out-of-range id 7
    start_frame(4);
    send(1, 32'h11110000, 32'd1);
    send(1, 32'h99990000, 32'd9);
    chk("err_dup_only", {io_dup_err, io_range_err}, {m_dup, m_range});
    send(7, 32'h77770000, 32'd7);
    chk("err_both", {io_dup_err, io_range_err}, 2'b11);
    send(0, 32'h00000000, 32'd0);
    send(2, 32'h22220000, 32'd2);
    send(3, 32'h33330000, 32'd3);
    send(0, 32'h0f0f0000, 32'd15);
    chk("err_dup_below_ptr", io_dup_err, 1'b1);
    wait_done("err", 20);
    chk("err_sticky_idle", {io_dup_err, io_range_err}, 2'b11);

    // Zero rays: done two cycles after start, no output; flags cleared
    d0 = done_cnt;
    v0 = ovalid_cnt;
    start_frame(0);
    chk("zero_flags_cleared", {io_dup_err, io_range_err}, 2'b00);
    chk("zero_not_done_yet", io_done, 1'b0);
    tick();
    chk("zero_done", io_done, 1'b1);
    tick();
    chk("zero_done_pulses", done_cnt - d0, 1);
    chk("zero_no_output", ovalid_cnt - v0, 0);

    // Reset mid-frame, then a clean 3-hit/1-miss frame
    start_frame(4);
    io_out_ready = 1'b0;
    send(1, 32'h12340000, 32'd5);
    send(0, 32'h56780000, 32'd6);
    tick();
    chk("mid_out_pending", io_out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_outputs", {io_out_valid, io_out_rayId, io_out_hitT, io_out_hitIndex,
                            io_busy, io_done, io_dup_err, io_range_err, io_res_ready}, '0);
`ifdef RTP_RESULT_STATS_EN
    chk("mid_rst_counts", {io_hit_count, io_miss_count}, '0);
`endif
    exp_q.delete();
    tick();
    reset = 1'b0;
    io_out_ready = 1'b1;
    tick();
    start_frame(4);
    send(2, 32'h42000000, 32'd20);
    send(0, 32'h41000000, RTP_MISS_INDEX);
    send(3, 32'h43000000, 32'd30);
    send(1, 32'h40000000, 32'd40);
    wait_done("post_rst", 20);
    chk("post_rst_flags", {io_dup_err, io_range_err}, 2'b00);
`ifdef RTP_RESULT_STATS_EN
    chk("stats_hits", io_hit_count, m_hits);
    chk("stats_miss", io_miss_count, m_miss);
    chk("stats_hits_const", io_hit_count, 3);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
